sonic_tx_gearbox_66_40: RTL and testbench

Downstream consumer of the 66-bit Tx circular buffer. Pulls 66-bit blocks ({data[63:0], sync[1:0]}) by driving the buffer's rdreq. Repacks them into a continuous stream of 40-bit words for the PMA serializer, LSB first. Runs entirely in the Tx PMA clock domain, which is the buffer's rd_clk.

---
 rtl/sonic_tx_gearbox_66_40.sv | 62 ++++++
 tb/tb_sonic_tx_gearbox_66_40.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sonic_tx_gearbox_66_40.sv
// sonic_tx_gearbox_66_40: repacks 66-bit blocks from the Tx circular buffer into a continuous 40-bit PMA word stream
module sonic_tx_gearbox_66_40 #(
  parameter int RD_LATENCY = 2,
  parameter int BUF_W = 40 * (RD_LATENCY + 1) + 66
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        rdena,
  input  logic [65:0] data_in,
  output logic        rdreq,
  output logic [39:0] data_out,
  output logic        data_valid,
  output logic        underrun
);
  localparam int L = RD_LATENCY;
  localparam int OW = $clog2(BUF_W + 1);
  logic [OW-1:0] occ;
  logic [L-1:0] req_sr, sr_n;
  logic [BUF_W-1:0] bit_buf, shifted, ins, msk, buf_n;
  logic [11:0] off, occ_n, need;
  logic [3:0] infl_n;
  logic fire, cap, req_n, started;
  // req_sr[0] is the live rdreq flop; its top bit marks the block arriving on data_in this cycle
  assign rdreq = req_sr[0];
  // shift out a word first, then drop the arriving block in right after the remaining bits
  always_comb begin
    fire = occ >= OW'(40);
    cap = req_sr[L-1];
    off = 12'(occ) - (fire ? 12'd40 : 12'd0);
    occ_n = off + (cap ? 12'd66 : 12'd0);
    infl_n = 4'($countones(req_sr)) - 4'(cap);
    need = occ_n + 12'(infl_n) * 12'd66;
    req_n = rdena && need < 12'(40 * (L + 1));
    sr_n = L'({req_sr, req_n});
    shifted = fire ? bit_buf >> 40 : bit_buf;
    ins = BUF_W'(data_in) << off;
    msk = BUF_W'({66{1'b1}}) << off;
    buf_n = cap ? (shifted & ~msk) | ins : shifted;
  end
  // registered state, outputs and the sticky underrun flag
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      req_sr <= '0;
      occ <= '0;
      bit_buf <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      started <= 1'b0;
      underrun <= 1'b0;
    end else begin
      req_sr <= sr_n;
      occ <= OW'(occ_n);
      bit_buf <= buf_n;
      data_valid <= fire;
      started <= fire;
      if (fire) data_out <= bit_buf[39:0];
      if (rdena && started && !fire) underrun <= 1'b1;
    end
  end
  // the request rule must keep the bit count within the buffer
  a_no_overflow: assert property (@(posedge clk_in) disable iff (!reset_n) occ_n <= 12'(BUF_W));
endmodule

// File: tb/tb_sonic_tx_gearbox_66_40.sv
// tb_sonic_tx_gearbox_66_40: directed checks of the 66->40 gearbox plus a latency sweep
module tb_sonic_tx_gearbox_66_40;
  localparam logic [65:0] POISON = 66'h2_AAAA_AAAA_AAAA_AAAA;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_m = 1'b0, rst_s = 1'b0, ena_m = 1'b0, ena_s = 1'b0;
  int mode = 0;
  int total = 0, bad = 0;

  function automatic logic [65:0] blk(int md, int k);
    logic [63:0] kk = 64'(k);
    if (md == 1) return k == 0 ? 66'h3_FFFF_FFFF_FFFF_FFFD : 66'd0;
    if (md == 2) return {kk * 64'h9E37_79B9_7F4A_7C15, 2'b01};
    return {kk, 2'b01};
  endfunction

  function automatic logic ebit(int md, longint n);
    logic [65:0] b = blk(md, int'(n / 66));
    return b[n % 66];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_d
    localparam int L = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 3 : 4;
    logic rst_n, rdena, rdreq, dv, un, seen;
    logic [65:0] din;
    logic [39:0] dout, exp_w;
    logic [3:0] pipe;
    logic [4:0] vec;
    int kin, words, wbad, gaps, unders;
    longint nbit;
    assign rst_n = g == 0 ? rst_m : rst_s;
    assign rdena = g == 0 ? ena_m : ena_s;
    assign vec = {pipe, rdreq};
    assign din = vec[L-1] ? blk(g == 0 ? mode : 0, kin) : POISON;
    sonic_tx_gearbox_66_40 #(.RD_LATENCY(L)) dut (
      .clk_in(clk), .reset_n(rst_n), .rdena(rdena), .data_in(din),
      .rdreq(rdreq), .data_out(dout), .data_valid(dv), .underrun(un)
    );
    // circular buffer model: block for a request is on data_in RD_LATENCY-1 cycles after rdreq rises
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        pipe <= '0;
        kin <= 0;
      end else begin
        pipe <= vec[3:0];
        if (vec[L-1]) kin <= kin + 1;
      end
    // stream scoreboard: concatenated output words must equal concatenated blocks
    always @(negedge clk)
      if (!rst_n) begin
        nbit = 0; words = 0; wbad = 0; gaps = 0; unders = 0; seen = 1'b0;
      end else begin
        if (un) unders++;
        if (dv) begin
          for (int i = 0; i < 40; i++) exp_w[i] = ebit(g == 0 ? mode : 0, nbit + i);
          if (dout !== exp_w) wbad++;
          words++;
          nbit += 40;
          seen = 1'b1;
        end else if (seen && rdena) gaps++;
      end
  end

  typedef struct {
    int md;
    int cyc;
    logic [39:0] w0;
    logic [39:0] w1;
    int nw;
  } vec_t;
  vec_t tv[3];

  task automatic chk(string nm, logic [65:0] act, logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(int c, output logic [39:0] w0, output logic [39:0] w1);
    int n = 0;
    w0 = '0;
    w1 = '0;
    repeat (c) begin
      @(negedge clk);
      if (g_d[0].dv) begin
        if (n == 0) w0 = g_d[0].dout;
        if (n == 1) w1 = g_d[0].dout;
        n++;
      end
    end
    #1;
  endtask

  logic [39:0] w0, w1;
  logic [65:0] b6;
  int first, rq;
  logic got;

  initial begin
    tv[0] = '{0, 10, 40'h00_0000_0001, 40'h00_1400_0000, 7};
    tv[1] = '{1, 6, 40'hFF_FFFF_FFFD, 40'h00_03FF_FFFF, 3};
    tv[2] = '{2, 8, 40'h00_0000_0001, 40'hC1_5400_0000, 5};
    ena_s = 1'b1;
    ena_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rst_m = 1'b0;
      mode = tv[i].md;
      repeat (2) @(negedge clk);
      rst_m = 1'b1;
      run(tv[i].cyc, w0, w1);
      chk($sformatf("vec%0d_word0", i), w0, tv[i].w0);
      chk($sformatf("vec%0d_word1", i), w1, tv[i].w1);
      chk($sformatf("vec%0d_words", i), g_d[0].words, tv[i].nw);
      chk($sformatf("vec%0d_underrun", i), g_d[0].un, 0);
    end
    rst_m = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    rst_m = 1'b1;
    first = 0;
    rq = 0;
    for (int cy = 1; cy <= 340; cy++) begin
      @(negedge clk);
      if (g_d[0].dv && first == 0) first = cy;
      if (cy >= 100 && cy < 166 && g_d[0].rdreq) rq++;
    end
    #1;
    chk("first_valid_le6", first > 0 && first <= 6, 1);
    chk("rdreq_in_66", rq, 40);
    chk("long_words", g_d[0].words, 337);
    chk("long_stream", g_d[0].wbad, 0);
    chk("long_gaps", g_d[0].gaps, 0);
    chk("long_underrun", g_d[0].unders, 0);
    @(negedge clk);
    #3;
    rst_m = 1'b0;
    #1;
    chk("async_rst_rdreq", g_d[0].rdreq, 0);
    chk("async_rst_dout", g_d[0].dout, 0);
    chk("async_rst_valid", g_d[0].dv, 0);
    chk("async_rst_underrun", g_d[0].un, 0);
    repeat (2) @(negedge clk);
    rst_m = 1'b1;
    run(40, w0, w1);
    chk("restart_word0", w0, 40'h00_0000_0001);
    chk("restart_word1", w1, 40'h00_1400_0000);
    chk("restart_words", g_d[0].words, 37);
    chk("restart_stream", g_d[0].wbad, 0);
    rst_m = 1'b0;
    mode = 2;
    repeat (2) @(negedge clk);
    rst_m = 1'b1;
    rq = 0;
    for (int cy = 0; cy < 50 && rq < 7; cy++) begin
      @(negedge clk);
      if (g_d[0].rdreq) rq++;
    end
    ena_m = 1'b0;
    chk("drop_requests", rq, 7);
    repeat (20) @(negedge clk);
    #1;
    chk("drop_words", g_d[0].words, 11);
    chk("drop_valid_idle", g_d[0].dv, 0);
    chk("drop_no_new_req", g_d[0].rdreq, 0);
    chk("drop_underrun", g_d[0].un, 0);
    ena_m = 1'b1;
    got = 1'b0;
    w0 = '0;
    for (int cy = 0; cy < 20 && !got; cy++) begin
      @(negedge clk);
      if (g_d[0].dv) begin
        got = 1'b1;
        w0 = g_d[0].dout;
      end
    end
    b6 = blk(2, 6);
    chk("resume_seen", got, 1);
    chk("resume_residual22", w0[21:0], b6[65:44]);
    repeat (30) @(negedge clk);
    #1;
    chk("resume_stream", g_d[0].wbad, 0);
    chk("resume_underrun", g_d[0].un, 0);
    while ($time < 101000) @(negedge clk);
    #1;
    chk("sweep_l1_gaps", g_d[1].gaps, 0);
    chk("sweep_l1_underrun", g_d[1].unders, 0);
    chk("sweep_l1_stream", g_d[1].wbad, 0);
    chk("sweep_l1_words", g_d[1].words >= 9980, 1);
    chk("sweep_l3_gaps", g_d[2].gaps, 0);
    chk("sweep_l3_underrun", g_d[2].unders, 0);
    chk("sweep_l3_stream", g_d[2].wbad, 0);
    chk("sweep_l3_words", g_d[2].words >= 9980, 1);
    chk("sweep_l4_gaps", g_d[3].gaps, 0);
    chk("sweep_l4_underrun", g_d[3].unders, 0);
    chk("sweep_l4_stream", g_d[3].wbad, 0);
    chk("sweep_l4_words", g_d[3].words >= 9980, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
